// File: rtl/serial_rx_pkg.sv
// ============================================================================
// Module      : serial_rx_pkg
// Description : Shared types and constants for the serial frame receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_rx_pkg;

  localparam int c_DATA_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DATA      = 3'd1,
    ST_PARITY    = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  // Counter must hold 0..DATA_W.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_shifter.sv
// ============================================================================
// Module      : sipo_shifter
// Description : Serial-in parallel-out register, LSB-first, with clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sipo_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // New bits enter at the MSB so the first bit lands in bit 0 after WIDTH shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= {din, r_q[WIDTH-1:1]};
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ============================================================================
// Module      : serial_frame_rx
// Description : Serial frame receiver (start, DATA_W bits LSB first, optional
//               odd parity when SERIAL_RX_PARITY_EN is defined, stop) with a
//               valid/ready output and frame_err / overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = cnt_width(DATA_W);
  localparam logic [CW-1:0] c_LAST_BIT = CW'(DATA_W - 1);

  rx_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_shift_en;
  logic          w_clr;
  logic          w_good;
  logic          w_ferr;
  logic          w_par_ok;
  logic [DATA_W-1:0] w_sipo_q;

  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_frame_err;
  logic              r_overrun;

`ifdef SERIAL_RX_PARITY_EN
  logic r_par, w_par_nxt;
  // Running XOR of data and parity bits; odd parity means it ends at 1.
  assign w_par_ok = r_par;
`else
  assign w_par_ok = 1'b1;
`endif

  sipo_shifter #(
    .WIDTH (DATA_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr),
    .shift_en (w_shift_en),
    .din      (in),
    .q        (w_sipo_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
`ifdef SERIAL_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
`ifdef SERIAL_RX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_clr       = 1'b0;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!in) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
          w_clr       = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
          w_par_nxt   = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        w_shift_en = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        w_par_nxt  = r_par ^ in;
`endif
        if (r_cnt == c_LAST_BIT) begin
          w_cnt_nxt = '0;
`ifdef SERIAL_RX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          w_state_nxt = ST_STOP;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY: begin
        w_par_nxt   = r_par ^ in;
        w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (in) begin
          w_state_nxt = ST_IDLE;
          w_good      = w_par_ok;
          w_ferr      = !w_par_ok;
        end else begin
          // Line held low: wait for it to return high before hunting a start.
          w_state_nxt = ST_WAIT_IDLE;
          w_ferr      = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (in) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_good && r_out_valid && !out_ready;
      // A byte being accepted this cycle frees the slot for a new one.
      if (w_good && (!r_out_valid || out_ready)) begin
        r_out_data  <= w_sipo_q;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// ============================================================================
// Module      : tb_serial_frame_rx
// Description : Scoreboard bench for serial_frame_rx (honours SERIAL_RX_PARITY_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_frame_rx;

  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              overrun;

  int n_cmp;
  int n_fail;
  int cyc;
  int rdy_mode;
  bit slot_full;

  logic [DATA_W-1:0] exp_data[$];
  int                exp_err[$];
  int                exp_ovr[$];

  serial_frame_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line cycle; the model applies the frame rules to the slot holding a byte.
  task automatic drive_cycle(input bit b, input bit stop, input bit good,
                             input logic [DATA_W-1:0] d);
    @(posedge clk);
    #1;
    cyc++;
    in = b;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = stop;
    endcase
    if (stop && good) begin
      if (!slot_full || out_ready) begin
        exp_data.push_back(d);
        slot_full = 1'b1;
      end else begin
        exp_ovr.push_back(cyc + 1);
      end
    end else if (slot_full && out_ready) begin
      slot_full = 1'b0;
    end
    if (stop && !good) exp_err.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, '0);
  endtask

  // kind: 0 good, 1 bad stop bit, 2 bad parity
  task automatic send_frame(input logic [DATA_W-1:0] d, input int kind);
    bit pb;
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DATA_W; i++) drive_cycle(d[i], 1'b0, 1'b0, '0);
`ifdef SERIAL_RX_PARITY_EN
    pb = (kind == 2) ? (^d) : ~(^d);
    drive_cycle(pb, 1'b0, 1'b0, '0);
`else
    pb = 1'b0;
`endif
    drive_cycle((kind == 1) ? 1'b0 : 1'b1, 1'b1, (kind == 0), d);
    if (kind == 1) begin
      int nz;
      nz = $urandom_range(0, 3);
      for (int i = 0; i < nz; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0);
      drive_cycle(1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b data=%h ferr=%b ovr=%b, required all 0",
               tag, out_valid, out_data, frame_err, overrun);
    end
  endtask

  task automatic check_pulse(input string tag, input logic act, inout int q[$]);
    bit exp;
    while (q.size() > 0 && q[0] < cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no pulse at cycle %0d, required one", tag, q[0]);
      void'(q.pop_front());
    end
    exp = (q.size() > 0 && q[0] == cyc);
    if (exp || act) begin
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: cycle %0d got %b, required %b", tag, cyc, act, exp);
      end
      if (exp) void'(q.pop_front());
    end
  endtask

  // Monitor: compare handshakes and pulses against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_data.size() == 0) begin
          n_fail++;
          $display("FAIL data: got unexpected byte %h, required none", out_data);
        end else begin
          if (out_data !== exp_data[0]) begin
            n_fail++;
            $display("FAIL data: got %h, required %h", out_data, exp_data[0]);
          end
          void'(exp_data.pop_front());
        end
      end
      check_pulse("frame_err", frame_err, exp_err);
      check_pulse("overrun", overrun, exp_ovr);
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; rdy_mode = 1; slot_full = 1'b0;
    in = 1'b1; out_ready = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset_state");
    @(posedge clk); #1 reset = 1'b0;

    // Frame 8'h35 with ready high.
    idle(3);
    send_frame(8'h35, 0);
    idle(3);

    // Bad stop bit, then 0,0,1.
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DATA_W; i++) drive_cycle(1'((8'h35 >> i) & 1), 1'b0, 1'b0, '0);
`ifdef SERIAL_RX_PARITY_EN
    drive_cycle(~(^8'h35), 1'b0, 1'b0, '0);
`endif
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h35);
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    drive_cycle(1'b1, 1'b0, 1'b0, '0);
    idle(3);

    // Back-to-back A5, 3C with ready low: overrun, then drain A5.
    rdy_mode = 0;
    send_frame(8'hA5, 0);
    send_frame(8'h3C, 0);
    rdy_mode = 1;
    idle(4);

    // Second frame completes in the cycle the first is accepted.
    rdy_mode = 3;
    send_frame(8'hA5, 0);
    send_frame(8'h3C, 0);
    rdy_mode = 1;
    idle(4);

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h07, 0);
    send_frame(8'h07, 2);
    idle(3);
`endif

    // Reset four cycles into a frame, then 8'h81.
    drive_cycle(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive_cycle(1'((8'h81 >> i) & 1), 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    cyc++;
    reset = 1'b1;
    slot_full = 1'b0;
    in = 1'b1;
    @(posedge clk); #2;
    check_reset_outputs("reset_midframe");
    @(posedge clk); #1 reset = 1'b0;
    cyc++;
    idle(2);
    send_frame(8'h81, 0);
    idle(3);

    // Randomized frames, gaps and ready patterns.
    for (int f = 0; f < 150; f++) begin
      int k;
      int r;
      r = $urandom_range(0, 99);
`ifdef SERIAL_RX_PARITY_EN
      k = (r < 70) ? 0 : (r < 85) ? 1 : 2;
`else
      k = (r < 80) ? 0 : 1;
`endif
      rdy_mode = $urandom_range(0, 3);
      send_frame(DATA_W'($urandom), k);
      idle($urandom_range(0, 2));
    end

    rdy_mode = 1;
    idle(20);
    n_cmp++;
    if (exp_data.size() != 0 || exp_err.size() != 0 || exp_ovr.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d/%0d pending data/err/ovr, required 0/0/0",
               exp_data.size(), exp_err.size(), exp_ovr.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
